// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: one result bit per clock.
// Optional DIV_ZERO_FLAG_EN adds a div_zero pulse that accompanies done on divide-by-zero.
module hilo_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            cancel,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic            div_zero
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000, OP_MULTU = 3'b001, OP_MADD = 3'b010, OP_MADDU = 3'b011,
        OP_DIV   = 3'b100, OP_DIVU  = 3'b101, OP_MTHI = 3'b110, OP_MTLO  = 3'b111
    } op_t;

    state_t            state;
    op_t               op_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   acc;     // product high half / partial remainder
    logic [XLEN-1:0]   shreg;   // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0]   opnd;    // multiplicand or divisor magnitude
    logic              neg_res;
    logic              neg_rem;
    logic              dz;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic              sgn_op;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    always_comb begin
        mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
        rem_sh  = {acc, shreg[XLEN-1]};
        diff    = rem_sh - {1'b0, opnd};
        product = {acc, shreg};
        prod_s  = neg_res ? -product : product;
        quo_s   = neg_res ? -shreg : shreg;
        rem_s   = neg_rem ? -acc : acc;
        sgn_op  = ~op[0];
        a_neg   = sgn_op & rs_val[XLEN-1];
        b_neg   = sgn_op & rt_val[XLEN-1];
        a_mag   = a_neg ? -rs_val : rs_val;
        b_mag   = b_neg ? -rt_val : rt_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_MULT;
            cnt     <= '0;
            acc     <= '0;
            shreg   <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero <= 1'b0;
`endif
            if (state != IDLE && cancel) begin
                state <= IDLE;
                busy  <= 1'b0;
                ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !cancel) begin
                            op_q <= op_t'(op);
                            if (op == OP_MTHI) begin
                                hi   <= rs_val;
                                done <= 1'b1;
                            end else if (op == OP_MTLO) begin
                                lo   <= rs_val;
                                done <= 1'b1;
                            end else if (op[2] && rt_val == '0) begin
                                // Divide by zero skips iteration; FINISH writes the raw dividend to hi
                                dz    <= 1'b1;
                                shreg <= rs_val;
                                state <= FINISH;
                                busy  <= 1'b1;
                                ready <= 1'b0;
                            end else begin
                                dz      <= 1'b0;
                                acc     <= '0;
                                shreg   <= op[2] ? a_mag : b_mag;
                                opnd    <= op[2] ? b_mag : a_mag;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= a_neg;
                                cnt     <= CNT_W'(XLEN - 1);
                                state   <= RUN;
                                busy    <= 1'b1;
                                ready   <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (op_q[2]) begin
                            if (!diff[XLEN]) begin
                                acc   <= diff[XLEN-1:0];
                                shreg <= {shreg[XLEN-2:0], 1'b1};
                            end else begin
                                acc   <= rem_sh[XLEN-1:0];
                                shreg <= {shreg[XLEN-2:0], 1'b0};
                            end
                        end else begin
                            acc   <= mul_sum[XLEN:1];
                            shreg <= {mul_sum[0], shreg[XLEN-1:1]};
                        end
                        if (cnt == '0) state <= FINISH;
                        else           cnt   <= cnt - 1'b1;
                    end
                    FINISH: begin
                        if (dz) begin
                            lo <= '1;
                            hi <= shreg;
`ifdef DIV_ZERO_FLAG_EN
                            div_zero <= 1'b1;
`endif
                        end else begin
                            case (op_q)
                                OP_MADD, OP_MADDU: {hi, lo} <= {hi, lo} + prod_s;
                                OP_DIV, OP_DIVU: begin
                                    lo <= quo_s;
                                    hi <= rem_s;
                                end
                                default: {hi, lo} <= prod_s;
                            endcase
                        end
                        dz    <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
